// File: rtl/noc_encoder_tx_if.sv
// Request, payload and NoC-output handshake bundle for the tile NoC packet builder.
// No logic and no latency; it only groups the signals.
// Backpressure travels on req_ready, pay_TREADY and stream_out_TREADY.
interface noc_encoder_tx_if #(
  parameter int XY_SZ  = 4,
  parameter int LEN_SZ = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [2*XY_SZ-1:0]   req_dest;
  logic [LEN_SZ-1:0]    req_len;
  logic [7:0]           req_opcode;

  logic                 pay_TVALID;
  logic [31:0]          pay_TDATA;
  logic                 pay_TREADY;

  logic                 stream_out_TVALID;
  logic [31:0]          stream_out_TDATA;
  logic [3:0]           stream_out_TKEEP;
  logic                 stream_out_TLAST;
  logic                 stream_out_TREADY;

  // Tile side: issues requests and payload, sinks the NoC stream.
  modport master (
    output req_valid, req_dest, req_len, req_opcode,
    output pay_TVALID, pay_TDATA,
    output stream_out_TREADY,
    input  req_ready, pay_TREADY,
    input  stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST
  );

  // Encoder side.
  modport slave (
    input  req_valid, req_dest, req_len, req_opcode,
    input  pay_TVALID, pay_TDATA,
    input  stream_out_TREADY,
    output req_ready, pay_TREADY,
    output stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST
  );
endinterface

// File: rtl/noc_encoder_tx.sv
// Builds one NoC packet (header, payload, optional XOR trailer under NOC_ENC_CHECKSUM_EN).
// Latency: an accepted request or payload word appears on the output one cycle later.
// Backpressure: single output register; readies follow stream_out_TREADY combinationally.
module noc_encoder_tx #(
  parameter int XY_SZ  = 4,
  parameter int LEN_SZ = 8
) (
  input  logic               clk_line,
  input  logic               clk_line_rst_low,
  input  logic [2*XY_SZ-1:0] HsrcId,
  noc_encoder_tx_if.slave    bus,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1
`ifdef NOC_ENC_CHECKSUM_EN
    , TRAILER = 2'd2
`endif
  } state_t;

  state_t              state, nxt_state;
  logic [LEN_SZ-1:0]   rem, rem_nxt;
  logic                or_vld, or_last;
  logic [31:0]         or_dat;
  logic                load_ok;
  logic                ld, ld_last;
  logic [31:0]         ld_dat;
  logic                req_rdy, pay_rdy;
  logic [31:0]         hdr;
`ifdef NOC_ENC_CHECKSUM_EN
  logic [31:0]         chk, chk_nxt;
`endif

  // The output register can take a new beat when empty or being drained this cycle.
  assign load_ok = !or_vld || bus.stream_out_TREADY;

  // Narrow fields are zero-extended into their byte lanes.
  assign hdr = {bus.req_opcode, 8'(bus.req_len), 8'(HsrcId), 8'(bus.req_dest)};

  // Next-state and output-register load selection.
  always_comb begin
    nxt_state = state;
    req_rdy   = 1'b0;
    pay_rdy   = 1'b0;
    ld        = 1'b0;
    ld_dat    = hdr;
    ld_last   = 1'b0;
    rem_nxt   = rem;
`ifdef NOC_ENC_CHECKSUM_EN
    chk_nxt   = chk;
`endif
    case (state)
      IDLE: begin
        req_rdy = load_ok;
        if (bus.req_valid && load_ok) begin
          ld      = 1'b1;
          ld_dat  = hdr;
          rem_nxt = bus.req_len;
`ifdef NOC_ENC_CHECKSUM_EN
          chk_nxt   = hdr;
          nxt_state = (bus.req_len == '0) ? TRAILER : PAYLOAD;
`else
          ld_last   = (bus.req_len == '0);
          nxt_state = (bus.req_len == '0) ? IDLE : PAYLOAD;
`endif
        end
      end
      PAYLOAD: begin
        pay_rdy = load_ok;
        if (bus.pay_TVALID && load_ok) begin
          ld      = 1'b1;
          ld_dat  = bus.pay_TDATA;
          rem_nxt = rem - LEN_SZ'(1);
`ifdef NOC_ENC_CHECKSUM_EN
          chk_nxt = chk ^ bus.pay_TDATA;
          if (rem == LEN_SZ'(1)) nxt_state = TRAILER;
`else
          if (rem == LEN_SZ'(1)) begin
            ld_last   = 1'b1;
            nxt_state = IDLE;
          end
`endif
        end
      end
`ifdef NOC_ENC_CHECKSUM_EN
      TRAILER: begin
        if (load_ok) begin
          ld        = 1'b1;
          ld_dat    = chk;
          ld_last   = 1'b1;
          nxt_state = IDLE;
        end
      end
`endif
      default: nxt_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) state <= IDLE;
    else                   state <= nxt_state;
  end

  // Remaining-word counter and running checksum.
  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      rem <= '0;
`ifdef NOC_ENC_CHECKSUM_EN
      chk <= '0;
`endif
    end else begin
      rem <= rem_nxt;
`ifdef NOC_ENC_CHECKSUM_EN
      chk <= chk_nxt;
`endif
    end
  end

  // Output register: loads a new beat or empties when drained; holds while stalled.
  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      or_vld  <= 1'b0;
      or_dat  <= '0;
      or_last <= 1'b0;
    end else if (load_ok) begin
      or_vld  <= ld;
      or_last <= ld && ld_last;
      if (ld) or_dat <= ld_dat;
    end
  end

  // Readies are masked during reset so every output reads 0 while it is held.
  assign bus.req_ready         = req_rdy && clk_line_rst_low;
  assign bus.pay_TREADY        = pay_rdy && clk_line_rst_low;
  assign bus.stream_out_TVALID = or_vld;
  assign bus.stream_out_TDATA  = or_dat;
  assign bus.stream_out_TLAST  = or_last;
  assign bus.stream_out_TKEEP  = 4'hF;
  assign busy                  = (state != IDLE);

endmodule

// File: tb/tb_noc_encoder_tx.sv
// Directed bench for noc_encoder_tx: fixed vectors, a small packet model and a beat monitor.
// Optional trailer section when NOC_ENC_CHECKSUM_EN is defined.
// Output-side stalls come from a fixed TREADY pattern.
module tb_noc_encoder_tx;

`ifdef NOC_ENC_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct packed {
    logic        last;
    logic [31:0] dat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  src_id = 8'h12;
  logic        busy;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  beat_t       got_q[$];
  int          got_cyc[$];
  beat_t       exp_q[$];
  logic [31:0] pay_vec[$];
  logic [23:0] req_vec[$];

  noc_encoder_tx_if #(.XY_SZ(4), .LEN_SZ(8)) bus ();

  noc_encoder_tx #(.XY_SZ(4), .LEN_SZ(8)) dut (
    .clk_line         (clk),
    .clk_line_rst_low (rst_n),
    .HsrcId           (src_id),
    .bus              (bus),
    .busy             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer, sampled half a cycle before the edge that takes it.
  always @(negedge clk) begin
    if (bus.stream_out_TVALID && bus.stream_out_TREADY) begin
      got_q.push_back({bus.stream_out_TLAST, bus.stream_out_TDATA});
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats of one packet; payload words start at pay_vec[first].
  task automatic expect_pkt(input logic [23:0] r, input int first);
    logic [7:0]  opc = r[23:16];
    logic [7:0]  len = r[15:8];
    logic [7:0]  dst = r[7:0];
    logic [31:0] h, x, w;
    h = {opc, len, src_id, dst};
    exp_q.push_back({(!CK && len == 8'd0), h});
    x = h;
    for (int i = 0; i < int'(len); i++) begin
      w = pay_vec[first + i];
      x = x ^ w;
      exp_q.push_back({(!CK && i == int'(len) - 1), w});
    end
    if (CK) exp_q.push_back({1'b1, x});
  endtask

  task automatic compare_q(input string tag);
    beat_t g;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 33'bx;
      chk($sformatf("%s_beat%0d", tag, i), 64'(g), 64'(exp_q[i]));
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  // Drive requests and payload from the vectors for ncyc cycles, checking stall stability.
  task automatic run(input int ncyc, input bit toggle);
    int          pidx = 0;
    int          ridx = 0;
    bit          tr, tp, held;
    logic [32:0] hb;
    for (int c = 0; c < ncyc; c++) begin
      bus.stream_out_TREADY = toggle ? (c % 3 == 0) : 1'b1;
      bus.pay_TVALID = (pidx < pay_vec.size());
      bus.pay_TDATA  = 32'h0;
      if (pidx < pay_vec.size()) bus.pay_TDATA = pay_vec[pidx];
      bus.req_valid = (ridx < req_vec.size());
      if (ridx < req_vec.size()) begin
        bus.req_opcode = req_vec[ridx][23:16];
        bus.req_len    = req_vec[ridx][15:8];
        bus.req_dest   = req_vec[ridx][7:0];
      end
      #1;
      tr   = bus.req_valid && bus.req_ready;
      tp   = bus.pay_TVALID && bus.pay_TREADY;
      held = bus.stream_out_TVALID && !bus.stream_out_TREADY;
      hb   = {bus.stream_out_TLAST, bus.stream_out_TDATA};
      tick();
      if (tr) ridx++;
      if (tp) pidx++;
      if (held) begin
        chk("hold_vld", 64'(bus.stream_out_TVALID), 64'd1);
        chk("hold_beat", 64'({bus.stream_out_TLAST, bus.stream_out_TDATA}), 64'(hb));
      end
    end
    bus.req_valid = 1'b0;
    bus.pay_TVALID = 1'b0;
    bus.stream_out_TREADY = 1'b1;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_dest = 8'h00;
    bus.req_len = 8'h00;
    bus.req_opcode = 8'h00;
    bus.pay_TVALID = 1'b0;
    bus.pay_TDATA = 32'h0;
    bus.stream_out_TREADY = 1'b1;

    // Reset state
    #12;
    chk("rst_vld", 64'(bus.stream_out_TVALID), 64'd0);
    chk("rst_dat", 64'(bus.stream_out_TDATA), 64'd0);
    chk("rst_last", 64'(bus.stream_out_TLAST), 64'd0);
    chk("rst_keep", 64'(bus.stream_out_TKEEP), 64'hF);
    chk("rst_req_rdy", 64'(bus.req_ready), 64'd0);
    chk("rst_pay_rdy", 64'(bus.pay_TREADY), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_req_rdy", 64'(bus.req_ready), 64'd1);
    tick();

    // Single packet len 3, latency and busy cycle by cycle
    clear_q();
    bus.req_valid = 1'b1;
    bus.req_dest = 8'h34;
    bus.req_opcode = 8'hA5;
    bus.req_len = 8'd3;
    bus.pay_TVALID = 1'b1;
    bus.pay_TDATA = 32'd1;
    #1;
    chk("t1_req_rdy", 64'(bus.req_ready), 64'd1);
    chk("t1_pay_early_rdy", 64'(bus.pay_TREADY), 64'd0);
    tick();
    bus.req_valid = 1'b0;
    bus.req_len = 8'd9;
    #1;
    chk("t1_hdr_vld", 64'(bus.stream_out_TVALID), 64'd1);
    chk("t1_hdr", 64'(bus.stream_out_TDATA), 64'hA5031234);
    chk("t1_hdr_last", 64'(bus.stream_out_TLAST), 64'd0);
    chk("t1_busy0", 64'(busy), 64'd1);
    chk("t1_pay_rdy", 64'(bus.pay_TREADY), 64'd1);
    tick();
    bus.pay_TDATA = 32'd2;
    #1;
    chk("t1_w1", 64'({bus.stream_out_TLAST, bus.stream_out_TDATA}), 64'({1'b0, 32'd1}));
    chk("t1_busy1", 64'(busy), 64'd1);
    tick();
    bus.pay_TDATA = 32'd3;
    #1;
    chk("t1_w2", 64'({bus.stream_out_TLAST, bus.stream_out_TDATA}), 64'({1'b0, 32'd2}));
    chk("t1_busy2", 64'(busy), 64'd1);
    tick();
    bus.pay_TVALID = 1'b0;
    #1;
    chk("t1_w3", 64'({bus.stream_out_TLAST, bus.stream_out_TDATA}), 64'({!CK, 32'd3}));
    chk("t1_busy3", 64'(busy), 64'(CK));
    tick();
    chk("t1_after_vld", 64'(bus.stream_out_TVALID), 64'(CK));
    tick();
    tick();
    pay_vec = '{32'd1, 32'd2, 32'd3};
    expect_pkt(24'hA50334, 0);
    compare_q("t1");

    // Header-only packet
    clear_q();
    pay_vec.delete();
    req_vec = '{24'h010000};
    bus.req_valid = 1'b1;
    bus.req_dest = 8'h00;
    bus.req_opcode = 8'h01;
    bus.req_len = 8'd0;
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t2_hdr", 64'({bus.stream_out_TLAST, bus.stream_out_TDATA}), 64'({!CK, 32'h01001200}));
    chk("t2_busy", 64'(busy), 64'(CK));
    tick();
    tick();
    tick();
    expect_pkt(req_vec[0], 0);
    compare_q("t2");

    // Len 4 with output stalls
    clear_q();
    req_vec = '{24'h3C0456};
    pay_vec = '{32'hD000, 32'hD001, 32'hD002, 32'hD003};
    run(24, 1'b1);
    chk("t3_xfers", 64'(got_q.size()), 64'(5 + int'(CK)));
    expect_pkt(req_vec[0], 0);
    compare_q("t3");

    // Two back-to-back len-2 packets
    clear_q();
    req_vec = '{24'h210211, 24'h220222};
    pay_vec = '{32'hAA01, 32'hAA02, 32'hBB01, 32'hBB02};
    run(12, 1'b0);
    expect_pkt(req_vec[0], 0);
    expect_pkt(req_vec[1], 2);
    compare_q("t4");
    chk("t4_span", 64'(got_cyc[got_cyc.size() - 1] - got_cyc[0]), 64'(exp_q.size() - 1));

    // Reset mid-packet, then a fresh len-1 packet
    clear_q();
    req_vec = '{24'h3C0456};
    pay_vec = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
    run(2, 1'b0);
    chk("t5_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 64'(bus.stream_out_TVALID), 64'd0);
    chk("t5_rst_last", 64'(bus.stream_out_TLAST), 64'd0);
    chk("t5_rst_dat", 64'(bus.stream_out_TDATA), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_req_rdy", 64'(bus.req_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_rel_req_rdy", 64'(bus.req_ready), 64'd1);
    tick();
    clear_q();
    req_vec = '{24'h770107};
    pay_vec = '{32'hCAFE};
    run(6, 1'b0);
    expect_pkt(req_vec[0], 0);
    compare_q("t5");

`ifdef NOC_ENC_CHECKSUM_EN
    // Trailer value for a len-2 packet
    clear_q();
    req_vec = '{24'hA50234};
    pay_vec = '{32'hF0F0F0F0, 32'h0000FFFF};
    run(8, 1'b0);
    chk("t6_trailer", 64'(got_q.size() > 3 ? got_q[3] : 33'bx), 64'({1'b1, 32'h55F21D3B}));
    expect_pkt(req_vec[0], 0);
    compare_q("t6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/noc_encoder_tx.md
# noc_encoder_tx

Transmit-side NoC packet builder for a tile. It accepts a send request (destination tile, opcode, payload length) plus a payload word stream. It emits one NoC packet on the 32-bit AXI-Stream NoC output: a header word carrying destination, source, length and opcode, then the payload words, with TLAST on the final beat. It is the counterpart of the tile's NoC header decoder and sits between tile logic and the outbound NoC port.

## Interface
- `XY_SZ`, 4: bits per X or Y coordinate; tile ID is `2*XY_SZ` bits; legal range 1..4.
- `LEN_SZ`, 8: width of the payload length field; legal range 1..8.
- `clk_line` in 1: the only clock.
- `clk_line_rst_low` in 1: reset, asynchronous and active-low.
- `HsrcId` in `2*XY_SZ`: own tile ID, written into the header source field; static.
- `req_valid` in 1: send request valid.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_dest` in `2*XY_SZ`: destination tile ID {Y,X}.
- `req_len` in `LEN_SZ`: number of payload words; 0 means a header-only packet.
- `req_opcode` in 8: opcode field.
- `pay_TVALID` in 1: payload word valid.
- `pay_TDATA` in 32: payload word.
- `pay_TREADY` out 1: payload word consumed when `pay_TVALID && pay_TREADY`.
- `stream_out_TVALID` out 1: NoC output valid.
- `stream_out_TDATA` out 32: NoC output data.
- `stream_out_TKEEP` out 4: always 4'hF.
- `stream_out_TLAST` out 1: last beat of the packet.
- `stream_out_TREADY` in 1: NoC output ready.
- `busy` out 1: high while the FSM is not IDLE.

## Operation
- Header layout:
  - [7:0] dest, zero-extended.
  - [15:8] `HsrcId`, zero-extended.
  - [23:16] `req_len`, zero-extended.
  - [31:24] opcode.
- Output register (OR): one register of {TVALID, TDATA, TLAST}. It loads when `load_ok = !stream_out_TVALID || stream_out_TREADY`. While `TVALID && !TREADY`, its contents are held stable.
- FSM states: IDLE, PAYLOAD.
- IDLE:
  - `req_ready = load_ok`.
  - On acceptance, the OR loads the header. TLAST is set to (`req_len == 0`).
  - A remaining counter `rem` loads `req_len`.
  - The FSM goes to PAYLOAD if `req_len != 0`; otherwise it stays in IDLE.
- PAYLOAD:
  - `pay_TREADY = load_ok`; `req_ready = 0`.
  - Each accepted payload word loads into the OR and decrements `rem`.
  - When `rem == 1` at acceptance, TLAST = 1 and the FSM goes to IDLE.
- A payload bubble (`pay_TVALID = 0`) while the OR drains clears `stream_out_TVALID`. Gaps are allowed inside a packet.
- `pay_TREADY` is 0 in IDLE. Payload presented before its request is never consumed.
- Packet boundary: a new request is accepted the cycle after the last payload word is accepted, provided `load_ok` holds.

## Timing
- Reset values:
  - All outputs 0 except `stream_out_TKEEP` = 4'hF.
  - `req_ready` is 1 while reset is released and the OR is empty.
  - FSM in IDLE; `rem` = 0.
- Latency: request accepted at edge N gives the header on the output from N+1. A payload word accepted at edge M appears from M+1.
- Throughput: one beat per cycle with `stream_out_TREADY` held high.
  - Packet of L payload words: L+1 cycles.
  - Back-to-back packets: no idle cycle between them.
- `req_ready` and `pay_TREADY` depend combinationally on `stream_out_TREADY`. There is no combinational path from `req_valid`/`pay_TVALID` to any ready signal.
- Reset asserted mid-packet:
  - Immediate asynchronous clear; the packet is truncated with no TLAST.
  - Downstream recovery is outside this block.
- `req_*` fields are sampled only at acceptance. Later changes have no effect.

## Configuration
- `NOC_ENC_CHECKSUM_EN` defined:
  - After the last payload word (or after the header when len = 0), one trailer beat is emitted. It equals the XOR of the header and all payload words, and carries TLAST.
  - The payload word before it has TLAST = 0.
  - The FSM gains a TRAILER state, entered after the last payload acceptance. It emits the trailer when `load_ok`, then returns to IDLE.
  - The header length field is unchanged and excludes the trailer.
- Not defined: no trailer, no TRAILER state, no XOR accumulator logic.

## Test plan
- Single packet, `HsrcId` = 8'h12, dest 8'h34, opcode 8'hA5, len 3, payload 1,2,3, TREADY = 1 → beats:
  - 32'hA5031234 (TLAST 0);
  - 1 and 2 (TLAST 0);
  - 3 (TLAST 1).
  - Header appears one cycle after acceptance; `busy` is high for 3 cycles.
- Len 0, opcode 8'h01, dest 8'h00, src 8'h12 → single beat 32'h01001200 with TLAST 1; FSM stays in IDLE.
- Len 4, TREADY toggling 1,0,0,1,… → every beat is held stable while stalled, no beat is lost or duplicated, and exactly 5 transfers occur.
- Two requests back-to-back, len 2 each → 6 consecutive valid beats, TLAST on beats 3 and 6.
- Reset asserted after header and one payload word of a len-4 packet → all outputs clear at once. After release, a new len-1 packet is sent correctly.
- `NOC_ENC_CHECKSUM_EN`, len 2, payload 32'hF0F0F0F0 and 32'h0000FFFF, header H → third data beat is H^32'hF0F00F0F with TLAST 1; the payload beats carry TLAST 0.
